bcd2bin_ctrl: RTL and testbench

//   Control FSM for the iterative BCD-to-binary converter (reverse double-dabble).

---
 rtl/bcd2bin_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_bcd2bin_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd2bin_ctrl.sv
// bcd2bin_ctrl -- control FSM for an iterative BCD-to-binary converter
// (reverse double-dabble).
//
// The controller sequences an external datapath through these steps:
//   1. Operand load (ld).
//   2. ITERS right-shifts (shift).
//   3. A per-digit "subtract 3 if >= 8" correction (adj) after every shift
//      except the last.
//
// The host side uses a start/busy/done handshake. done is a one-cycle pulse
// in the cycle where the datapath result is valid.
//
// ld, shift, adj, busy and done are Moore outputs: they are decoded from the
// state register only, so no input reaches them combinationally.
//
// Optional feature, macro BCD2BIN_CHECK_EN:
//   - Adds the bcd_ok input and the err output.
//   - An operand with an invalid digit skips the datapath entirely and goes
//     straight to DONE with err set.
//
// Legal parameter range: 2 <= ITERS <= 2**CW - 1.

module bcd2bin_ctrl #(
  parameter int ITERS = 16,
  parameter int CW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
`ifdef BCD2BIN_CHECK_EN
  input  logic          bcd_ok,
  output logic          err,
`endif
  output logic          ld,
  output logic          shift,
  output logic          adj,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] iter
);

  localparam logic [CW-1:0] C_ITERS = CW'(ITERS);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_ADJ   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_iter;
  logic [CW-1:0] w_iter_next;
  logic          w_last_shift;
  logic          w_accept;

`ifdef BCD2BIN_CHECK_EN
  logic          r_err;
  logic          w_err_next;
`endif

  // A start is only taken in IDLE, and an abort in the same cycle vetoes it.
  assign w_accept     = (r_state == S_IDLE) && start && !abort;

  // The shift that consumes the final remaining iteration ends the conversion.
  // Treating 0 the same way keeps the FSM from ever cycling without an end.
  assign w_last_shift = (r_iter <= C_ONE);

  // State, iteration counter and error flag registers; async reset to idle.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_iter  <= '0;
    end else begin
      r_state <= w_state_next;
      r_iter  <= w_iter_next;
    end
  end

`ifdef BCD2BIN_CHECK_EN
  // Error flag: updated only when a start is accepted, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_err_next;
    end
  end
`endif

  // Next-state, counter-update and error-update logic.
  // Priority: abort first, then the normal step for the current state.
  // NOTE: every signal gets a default before the case statement, so a missed
  // branch cannot infer a latch. It simply holds the current value.
  always_comb begin
    w_state_next = r_state;
    w_iter_next  = r_iter;
`ifdef BCD2BIN_CHECK_EN
    w_err_next   = r_err;
`endif

    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
`ifdef BCD2BIN_CHECK_EN
          if (bcd_ok) begin
            w_err_next   = 1'b0;
            w_state_next = S_LOAD;
          end else begin
            // Invalid operand: report it without touching the datapath.
            w_err_next   = 1'b1;
            w_state_next = S_DONE;
          end
`else
          w_state_next = S_LOAD;
`endif
        end
      end

      S_LOAD: begin
        if (abort) begin
          w_state_next = S_IDLE;
        end else begin
          w_iter_next  = C_ITERS;
          w_state_next = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (abort) begin
          w_state_next = S_IDLE;
        end else begin
          // Decrement only while non-zero, so the counter can never wrap.
          if (r_iter != '0) begin
            w_iter_next = r_iter - C_ONE;
          end
          w_state_next = w_last_shift ? S_DONE : S_ADJ;
        end
      end

      S_ADJ: begin
        w_state_next = abort ? S_IDLE : S_SHIFT;
      end

      S_DONE: begin
        // start is deliberately ignored here. This forces at least one IDLE
        // cycle between back-to-back conversions.
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Moore output decode.
  assign ld    = (r_state == S_LOAD);
  assign shift = (r_state == S_SHIFT);
  assign adj   = (r_state == S_ADJ);
  assign busy  = (r_state == S_LOAD) || (r_state == S_SHIFT) || (r_state == S_ADJ);
  assign done  = (r_state == S_DONE);
  assign iter  = r_iter;
`ifdef BCD2BIN_CHECK_EN
  assign err   = r_err;
`endif

  // Structural invariants of the sequencer.
  a_onehot_cmd : assert property (@(posedge clk) disable iff (rst)
    $onehot0({ld, shift, adj}));

  a_busy_done_excl : assert property (@(posedge clk) disable iff (rst)
    !(busy && done));

  a_iter_range : assert property (@(posedge clk) disable iff (rst)
    r_iter <= C_ITERS);

endmodule

// File: tb/tb_bcd2bin_ctrl.sv
// Self-checking bench for bcd2bin_ctrl.
//
// A cycle-position model predicts every output on every cycle. The model
// tracks the position within a conversion, where 0 means idle and
// 1..2*ITERS+1 index the cycles of a conversion. It derives outputs from the
// rules for ld, shift, adj, busy, done and iter.
//
// Directed scenarios add hand-computed literal expectations: pulse counts,
// cycle numbers and iter values.

module tb_bcd2bin_ctrl;

  localparam int ITERS = 16;
  localparam int CW    = 5;
  localparam int LAT   = 2 * ITERS + 1;   // 33: cycle number of done

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          ld, shift, adj, busy, done;
  logic [CW-1:0] iter;
`ifdef BCD2BIN_CHECK_EN
  logic          bcd_ok;
  logic          err;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd2bin_ctrl #(.ITERS(ITERS), .CW(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
`ifdef BCD2BIN_CHECK_EN
    .bcd_ok(bcd_ok),
    .err   (err),
`endif
    .ld    (ld),
    .shift (shift),
    .adj   (adj),
    .busy  (busy),
    .done  (done),
    .iter  (iter)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            m_pos;    // 0 idle, else cycle index within a conversion
  logic [CW-1:0] m_iter;
  logic          m_err;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pos  <= 0;
      m_iter <= '0;
      m_err  <= 1'b0;
    end else if (m_pos == 0) begin
      if (start && !abort) begin
`ifdef BCD2BIN_CHECK_EN
        if (!bcd_ok) begin
          m_pos <= LAT;
          m_err <= 1'b1;
        end else begin
          m_pos <= 1;
          m_err <= 1'b0;
        end
`else
        m_pos <= 1;
`endif
      end
    end else if (abort || m_pos == LAT) begin
      m_pos <= 0;
    end else begin
      // Cycle m_pos+1 has seen m_pos/2 completed shifts before it.
      m_pos  <= m_pos + 1;
      m_iter <= CW'(ITERS - m_pos / 2);
    end
  end

  // {ld, shift, adj, busy, done} expected at conversion position p.
  function automatic logic [4:0] flags_of(input int p);
    logic e_ld, e_sh, e_adj, e_busy, e_done;
    e_ld   = (p == 1);
    e_sh   = (p >= 2) && (p <= 2 * ITERS) && (p % 2 == 0);
    e_adj  = (p >= 3) && (p <= 2 * ITERS - 1) && (p % 2 == 1);
    e_busy = (p >= 1) && (p <= 2 * ITERS);
    e_done = (p == LAT);
    return {e_ld, e_sh, e_adj, e_busy, e_done};
  endfunction

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    check("model_outputs", {ld, shift, adj, busy, done, iter}, {flags_of(m_pos), m_iter});
`ifdef BCD2BIN_CHECK_EN
    check("model_err", err, m_err);
`endif
  end

  // ---------------- directed helpers ----------------

  // Runs one conversion from an IDLE negedge and gathers statistics.
  task automatic run_nominal(output int first_ld, output int n_sh, output int n_adj,
                             output int n_busy, output int done_cyc, output int n_done,
                             output int iter_c2, output int iter_dn);
    first_ld = 0; n_sh = 0; n_adj = 0; n_busy = 0;
    done_cyc = 0; n_done = 0; iter_c2 = -1; iter_dn = -1;
    start = 1'b1;
    for (int c = 1; c <= LAT + 3; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (ld && first_ld == 0) first_ld = c;
      if (shift) n_sh++;
      if (adj) n_adj++;
      if (busy) n_busy++;
      if (done) begin
        n_done++;
        done_cyc = c;
        iter_dn  = int'(iter);
      end
      if (c == 2) iter_c2 = int'(iter);
    end
  endtask

  // Waits (bounded) until the DUT is neither busy nor signalling done.
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, (busy || done)}, 32'd0);
    @(negedge clk);
  endtask

  // Aborts after shift number k: during that shift, or in the following ADJ.
  task automatic run_abort(input int k, input bit in_adj, input int exp_iter, input int exp_cyc);
    int  n_sh;
    int  ab_cyc;
    bit  seen_done;
    n_sh = 0; ab_cyc = 0; seen_done = 1'b0;
    start = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (abort) begin
        abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_iter", {27'd0, iter}, exp_iter);
      end
      if (shift) n_sh++;
      if (done) seen_done = 1'b1;
      if (ab_cyc == 0 && n_sh == k && (in_adj ? adj : shift)) begin
        abort  = 1'b1;
        ab_cyc = c;
      end
    end
    check("abort_cycle", ab_cyc, exp_cyc);
    check("abort_no_done", {31'd0, seen_done}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int first_ld, n_sh, n_adj, n_busy, done_cyc, n_done, iter_c2, iter_dn;
    int ld_mid, ld2, first_done;

    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
`ifdef BCD2BIN_CHECK_EN
    bcd_ok = 1'b1;
`endif

    // 1. Reset held for three cycles, then released.
    repeat (3) @(negedge clk);
    check("reset_outputs", {ld, shift, adj, busy, done, iter}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_reset_outputs", {ld, shift, adj, busy, done, iter}, 32'd0);

    // 2. Nominal conversion.
    run_nominal(first_ld, n_sh, n_adj, n_busy, done_cyc, n_done, iter_c2, iter_dn);
    check("nom_first_ld", first_ld, 1);
    check("nom_shifts", n_sh, 16);
    check("nom_adjs", n_adj, 15);
    check("nom_busy_cycles", n_busy, 32);
    check("nom_done_cycle", done_cyc, 33);
    check("nom_done_count", n_done, 1);
    check("nom_iter_cycle2", iter_c2, 16);
    check("nom_iter_at_done", iter_dn, 0);
    wait_idle("nom_idle_timeout");

    // 3. start held high for 40 cycles.
    ld_mid = 0; ld2 = 0; first_done = 0;
    start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 40) start = 1'b0;
      if (ld && c >= 2 && c <= 34) ld_mid++;
      if (ld && c >= 35 && ld2 == 0) ld2 = c;
      if (done && first_done == 0) first_done = c;
    end
    check("ovl_first_done", first_done, 33);
    check("ovl_no_extra_ld", ld_mid, 0);
    check("ovl_second_ld", ld2, 35);
    wait_idle("ovl_idle_timeout");

    // 4. Abort scenarios.
    // Abort in the ADJ after the 5th shift (cycle 11): 11 remaining.
    run_abort(5, 1'b1, 11, 11);
    // Abort during the 3rd shift (cycle 6): decrement suppressed, 14 held.
    run_abort(3, 1'b0, 14, 6);

    // Abort together with start in IDLE: the start is dropped.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("idle_abort_busy", {31'd0, busy}, 32'd0);
    check("idle_abort_ld", {31'd0, ld}, 32'd0);
    @(negedge clk);

    // A fresh start after the aborts completes normally.
    run_nominal(first_ld, n_sh, n_adj, n_busy, done_cyc, n_done, iter_c2, iter_dn);
    check("post_abort_done_cycle", done_cyc, 33);
    check("post_abort_shifts", n_sh, 16);
    wait_idle("post_abort_idle_timeout");

    // 5. Asynchronous reset in the middle of an ADJ cycle.
    start = 1'b1;
    n_adj = 0;
    for (int c = 1; c <= 20 && n_adj < 3; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (adj) n_adj++;
    end
    check("async_pre_adj", {31'd0, adj}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_outputs", {ld, shift, adj, busy, done, iter}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_nominal(first_ld, n_sh, n_adj, n_busy, done_cyc, n_done, iter_c2, iter_dn);
    check("post_rst_done_cycle", done_cyc, 33);
    check("post_rst_adjs", n_adj, 15);
    wait_idle("post_rst_idle_timeout");

`ifdef BCD2BIN_CHECK_EN
    // 6. Invalid operand goes straight to DONE; a valid one runs normally.
    bcd_ok = 1'b0;
    start  = 1'b1;
    first_ld = 0; done_cyc = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start  = 1'b0;
        bcd_ok = 1'b1;
      end
      if (ld) first_ld = c;
      if (done && done_cyc == 0) done_cyc = c;
    end
    check("chk_bad_done_cycle", done_cyc, 1);
    check("chk_bad_no_ld", first_ld, 0);
    check("chk_bad_err", {31'd0, err}, 32'd1);
    run_nominal(first_ld, n_sh, n_adj, n_busy, done_cyc, n_done, iter_c2, iter_dn);
    check("chk_ok_err", {31'd0, err}, 32'd0);
    check("chk_ok_done_cycle", done_cyc, 33);
    wait_idle("chk_idle_timeout");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
